// File: rtl/photo_store_ctrl.sv
// Photo store controller: moves one frame between frame-buffer port B and an SD
// card slot, one 512-byte sector (256 sixteen-bit words) at a time.
module photo_store_ctrl #(
    parameter int          PIX_W     = 12,
    parameter int          ADDR_W    = 19,
    parameter int          FRAME_SEC = 1200,
    parameter int          SLOT_N    = 16,
    parameter logic [31:0] BASE_SEC  = 32'd8192,
    parameter int          TO_CYC    = 1_000_000,
    localparam int         SW        = (SLOT_N > 1) ? $clog2(SLOT_N) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [SW-1:0]     cmd_slot,
    output logic [1:0]        mode,
    output logic              cam_wr_gate,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic [PIX_W-1:0]  buf_wdata,
    input  logic [PIX_W-1:0]  buf_rdata,
    input  logic              sd_init_done,
    output logic              wr_start_en,
    input  logic              wr_busy,
    input  logic              wr_req,
    output logic [15:0]       wr_data,
    output logic              rd_start_en,
    input  logic              rd_busy,
    input  logic              rd_val_en,
    input  logic [15:0]       rd_val_data,
    output logic [31:0]       sec_addr,
    output logic              done,
    output logic              err
);

    localparam int FRAME_WORDS = FRAME_SEC * 256;
    localparam int WCW         = $clog2(FRAME_WORDS);
    localparam int SCW         = $clog2(FRAME_SEC + 1);
    localparam int TCW         = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        S_LIVE, S_SAVE_ST, S_SAVE_XF, S_LOAD_ST, S_LOAD_XF, S_ERR
    } state_t;

    state_t         state;
    logic [WCW-1:0] word_cnt;
    logic [8:0]     sec_words;
    logic [SCW-1:0] sec_cnt;
    logic [TCW-1:0] to_cnt;

    logic is_save, xfer_evt, xfer_busy, sec_full, to_hit, cmd_go;
    logic unused_hi;

    assign is_save   = (state == S_SAVE_ST) || (state == S_SAVE_XF);
    assign xfer_evt  = is_save ? wr_req  : rd_val_en;
    assign xfer_busy = is_save ? wr_busy : rd_busy;
    assign sec_full  = (sec_words == 9'd256);
    assign to_hit    = (to_cnt == TCW'(TO_CYC - 1));
    assign cmd_go    = cmd_valid && sd_init_done && (cmd_op == 2'd1 || cmd_op == 2'd2);

    assign buf_wdata = rd_val_data[PIX_W-1:0];
    assign wr_data   = 16'(buf_rdata);
    assign unused_hi = ^rd_val_data;

    always_comb begin
        mode = 2'd0;
        case (state)
            S_SAVE_ST, S_SAVE_XF: mode = 2'd1;
            S_LOAD_ST, S_LOAD_XF: mode = 2'd2;
            S_ERR:                mode = 2'd3;
            default:              mode = 2'd0;
        endcase
        cam_wr_gate = (state == S_LIVE);
        err         = (state == S_ERR);
        // Outside LIVE port B follows the word counter so read data is ready before the next wr_req
        buf_addr    = (state == S_LIVE) ? vga_addr : ADDR_W'(word_cnt);
        buf_we      = (state == S_LOAD_XF) && rd_val_en && !sec_full && sd_init_done && !to_hit;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_LIVE;
            word_cnt    <= '0;
            sec_words   <= '0;
            sec_cnt     <= '0;
            to_cnt      <= '0;
            sec_addr    <= BASE_SEC;
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_LIVE: begin
                    to_cnt <= '0;
                    if (cmd_go) begin
                        word_cnt  <= '0;
                        sec_words <= '0;
                        sec_cnt   <= '0;
                        sec_addr  <= BASE_SEC + 32'(cmd_slot) * 32'(FRAME_SEC);
                        state     <= (cmd_op == 2'd1) ? S_SAVE_ST : S_LOAD_ST;
                    end
                end
                S_ERR: begin
                    to_cnt <= '0;
                    if (cmd_valid && cmd_op == 2'd0) state <= S_LIVE;
                end
                S_SAVE_ST, S_LOAD_ST, S_SAVE_XF, S_LOAD_XF: begin
                    if (!sd_init_done || to_hit) begin
                        state  <= S_ERR;
                        to_cnt <= '0;
                    end else if (state == S_SAVE_ST || state == S_LOAD_ST) begin
                        if (!xfer_busy) begin
                            to_cnt      <= '0;
                            wr_start_en <= is_save;
                            rd_start_en <= !is_save;
                            state       <= is_save ? S_SAVE_XF : S_LOAD_XF;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else if (xfer_evt && !sec_full) begin
                        to_cnt    <= '0;
                        sec_words <= sec_words + 9'd1;
                        if (word_cnt != WCW'(FRAME_WORDS - 1)) word_cnt <= word_cnt + 1'b1;
                    end else if (sec_full && !xfer_busy) begin
                        // Sector finished: either the frame is complete or the next sector starts
                        to_cnt    <= '0;
                        sec_words <= '0;
                        if (sec_cnt == SCW'(FRAME_SEC - 1)) begin
                            done  <= 1'b1;
                            state <= S_LIVE;
                        end else begin
                            sec_cnt  <= sec_cnt + 1'b1;
                            sec_addr <= sec_addr + 32'd1;
                            state    <= is_save ? S_SAVE_ST : S_LOAD_ST;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= S_LIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_photo_store_ctrl.sv
// Randomized bench for photo_store_ctrl: behavioural SD card and frame-buffer
// models plus an expected frame image kept as a plain array.
module tb_photo_store_ctrl;

    localparam int PIX_W     = 12;
    localparam int ADDR_W    = 19;
    localparam int FRAME_SEC = 2;
    localparam int SLOT_N    = 16;
    localparam int TO_CYC    = 100;
    localparam int BASE      = 8192;
    localparam int FW        = FRAME_SEC * 256;

    logic              sys_clk, sys_rst;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_slot;
    logic [1:0]        mode;
    logic              cam_wr_gate;
    logic [ADDR_W-1:0] vga_addr;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_we;
    logic [PIX_W-1:0]  buf_wdata;
    logic [PIX_W-1:0]  buf_rdata;
    logic              sd_init_done;
    logic              wr_start_en, wr_busy, wr_req;
    logic [15:0]       wr_data;
    logic              rd_start_en, rd_busy, rd_val_en;
    logic [15:0]       rd_val_data;
    logic [31:0]       sec_addr;
    logic              done, err;

    photo_store_ctrl #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .FRAME_SEC(FRAME_SEC), .SLOT_N(SLOT_N),
        .BASE_SEC(32'd8192), .TO_CYC(TO_CYC)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_slot(cmd_slot), .mode(mode), .cam_wr_gate(cam_wr_gate), .vga_addr(vga_addr),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .sd_init_done(sd_init_done), .wr_start_en(wr_start_en), .wr_busy(wr_busy),
        .wr_req(wr_req), .wr_data(wr_data), .rd_start_en(rd_start_en), .rd_busy(rd_busy),
        .rd_val_en(rd_val_en), .rd_val_data(rd_val_data), .sec_addr(sec_addr),
        .done(done), .err(err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame buffer port B: one-cycle read latency, filled with 0..FW-1 while init_mem is high
    logic [PIX_W-1:0] mem [0:FW-1];
    logic             init_mem;
    always @(posedge sys_clk) begin
        if (init_mem) begin
            for (int i = 0; i < FW; i++) mem[i] <= PIX_W'(i);
        end else if (buf_we) begin
            mem[buf_addr[8:0]] <= buf_wdata;
        end
        buf_rdata <= mem[buf_addr[8:0]];
    end

    int wr_pulses = 0, rd_pulses = 0, done_pulses = 0, both_hi = 0, gate_bad = 0;
    always @(negedge sys_clk) begin
        if (wr_start_en) wr_pulses++;
        if (rd_start_en) rd_pulses++;
        if (done) done_pulses++;
        if (wr_start_en && rd_start_en) both_hi++;
        if (mode != 2'd0 && cam_wr_gate) gate_bad++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [PIX_W-1:0] img [0:FW-1];

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] slot);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_slot  = slot;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input bit want_wr, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (want_wr ? wr_start_en : rd_start_en) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) checkOutput(want_wr ? "wr_start_seen" : "rd_start_seen", 0, 1);
    endtask

    task automatic wait_live();
        for (int k = 0; k < 50 && mode != 2'd0; k++) tick(1);
    endtask

    task automatic run_save(input int slot, input bit poke);
        bit seen;
        int wr0, d0;
        wr0 = wr_pulses;
        d0  = done_pulses;
        applyStimulus(2'd1, 4'(slot));
        for (int s = 0; s < FRAME_SEC; s++) begin
            wait_start(1'b1, seen);
            if (!seen) return;
            checkOutput("save_sec_addr", sec_addr, BASE + slot * FRAME_SEC + s);
            wr_busy = 1'b1;
            for (int i = 0; i < 256; i++) begin
                tick(1 + $urandom_range(0, 2));
                wr_req = 1'b1;
                checkOutput("save_wr_data", wr_data, {4'd0, img[s*256+i]});
                if (poke && s == 0 && (i == 100 || i == 150)) begin
                    cmd_valid = 1'b1;
                    cmd_op    = (i == 100) ? 2'd2 : 2'd0;
                    cmd_slot  = 4'd7;
                end
                tick(1);
                wr_req    = 1'b0;
                cmd_valid = 1'b0;
            end
            // a surplus request past the sector end must be ignored
            tick(2);
            wr_req = 1'b1;
            tick(1);
            wr_req = 1'b0;
            tick(2);
            wr_busy = 1'b0;
        end
        wait_live();
        tick(2);
        checkOutput("save_mode_end", mode, 0);
        checkOutput("save_done_cnt", done_pulses - d0, 1);
        checkOutput("save_start_cnt", wr_pulses - wr0, FRAME_SEC);
    endtask

    task automatic run_load(input int slot);
        bit seen;
        int rd0, d0, nmis, gap;
        logic [15:0] d;
        rd0 = rd_pulses;
        d0  = done_pulses;
        applyStimulus(2'd2, 4'(slot));
        for (int s = 0; s < FRAME_SEC; s++) begin
            wait_start(1'b0, seen);
            if (!seen) return;
            checkOutput("load_sec_addr", sec_addr, BASE + slot * FRAME_SEC + s);
            rd_busy = 1'b1;
            for (int i = 0; i < 256; i++) begin
                gap = $urandom_range(0, 2);
                if (gap != 0) begin
                    rd_val_en = 1'b0;
                    tick(gap);
                end
                d = (s == 0 && i == 0) ? 16'hFABC : 16'($urandom);
                img[s*256+i] = d[PIX_W-1:0];
                rd_val_en   = 1'b1;
                rd_val_data = d;
                #1;
                checkOutput("load_buf_we", buf_we, 1);
                checkOutput("load_buf_addr", buf_addr, s * 256 + i);
                checkOutput("load_buf_wdata", buf_wdata, d[PIX_W-1:0]);
                tick(1);
            end
            rd_val_en = 1'b0;
            tick(1);
            rd_val_en   = 1'b1;
            rd_val_data = 16'h0FFF;
            #1;
            checkOutput("load_extra_we", buf_we, 0);
            tick(1);
            rd_val_en = 1'b0;
            tick(2);
            rd_busy = 1'b0;
        end
        wait_live();
        tick(2);
        nmis = 0;
        for (int i = 0; i < FW; i++) if (mem[i] !== img[i]) nmis++;
        checkOutput("load_mem_mismatch", nmis, 0);
        checkOutput("load_done_cnt", done_pulses - d0, 1);
        checkOutput("load_start_cnt", rd_pulses - rd0, FRAME_SEC);
    endtask

    initial begin
        int n, p0;
        bit seen;
        logic [ADDR_W-1:0] v;

        sys_rst = 1'b1; init_mem = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_slot = 4'd0;
        vga_addr = '0; sd_init_done = 1'b1;
        wr_busy = 1'b0; wr_req = 1'b0; rd_busy = 1'b0; rd_val_en = 1'b0; rd_val_data = 16'd0;
        for (int i = 0; i < FW; i++) img[i] = PIX_W'(i);
        tick(3);
        checkOutput("rst_mode", mode, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_gate", cam_wr_gate, 1);
        checkOutput("rst_sec_addr", sec_addr, BASE);
        checkOutput("rst_pulses", {wr_start_en, rd_start_en, done}, 0);
        sys_rst = 1'b0; init_mem = 1'b0;
        tick(1);

        for (int k = 0; k < 4; k++) begin
            v = ADDR_W'($urandom);
            vga_addr = v;
            #1;
            checkOutput("live_buf_addr", buf_addr, v);
            checkOutput("live_buf_we", buf_we, 0);
            tick(1);
        end

        // ops 0/3, and any command while the card is not ready, leave LIVE untouched
        p0 = wr_pulses + rd_pulses;
        applyStimulus(2'd0, 4'd2);
        applyStimulus(2'd3, 4'd2);
        sd_init_done = 1'b0;
        applyStimulus(2'd1, 4'd2);
        sd_init_done = 1'b1;
        tick(3);
        checkOutput("ignore_mode", mode, 0);
        checkOutput("ignore_pulses", wr_pulses + rd_pulses - p0, 0);

        run_save(2, 1'b1);
        run_load(0);
        run_save(5, 1'b0);

        // busy stuck high: timeout into ERR, then only a clear command leaves
        wr_busy = 1'b1;
        p0 = wr_pulses;
        applyStimulus(2'd1, 4'd1);
        n = 0;
        for (int k = 0; k < 300 && mode != 2'd3; k++) begin
            if (mode == 2'd1) n++;
            tick(1);
        end
        checkOutput("timeout_cycles", n, TO_CYC);
        checkOutput("timeout_err", err, 1);
        checkOutput("timeout_gate", cam_wr_gate, 0);
        checkOutput("timeout_no_start", wr_pulses - p0, 0);
        applyStimulus(2'd1, 4'd3);
        checkOutput("err_ignores_save", mode, 3);
        applyStimulus(2'd0, 4'd0);
        checkOutput("err_clear_mode", mode, 0);
        checkOutput("err_clear_err", err, 0);
        wr_busy = 1'b0;
        tick(2);

        // SD card drops out mid-load
        applyStimulus(2'd2, 4'd4);
        wait_start(1'b0, seen);
        rd_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_val_en = 1'b1; rd_val_data = 16'($urandom);
            tick(1);
            rd_val_en = 1'b0;
            tick(1);
        end
        sd_init_done = 1'b0;
        tick(1);
        checkOutput("sd_drop_mode", mode, 3);
        checkOutput("sd_drop_we", buf_we, 0);
        sd_init_done = 1'b1;
        rd_busy = 1'b0;
        applyStimulus(2'd0, 4'd0);
        checkOutput("sd_drop_clear", mode, 0);
        tick(2);

        // reset in the middle of a load
        applyStimulus(2'd2, 4'd3);
        wait_start(1'b0, seen);
        checkOutput("rst_load_sec_addr", sec_addr, BASE + 3 * FRAME_SEC);
        rd_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_val_en = 1'b1; rd_val_data = 16'($urandom);
            tick(1);
        end
        sys_rst = 1'b1;
        tick(1);
        checkOutput("midrst_mode", mode, 0);
        checkOutput("midrst_we", buf_we, 0);
        checkOutput("midrst_err", err, 0);
        checkOutput("midrst_sec_addr", sec_addr, BASE);
        sys_rst = 1'b0; rd_val_en = 1'b0; rd_busy = 1'b0;
        p0 = wr_pulses + rd_pulses;
        tick(30);
        checkOutput("midrst_no_start", wr_pulses + rd_pulses - p0, 0);
        checkOutput("midrst_live", mode, 0);

        checkOutput("start_overlap", both_hi, 0);
        checkOutput("gate_outside_live", gate_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/photo_store_ctrl.md
PHOTO_STORE_CTRL -- requirements
Module: photo_store_ctrl

Interface
REQ-001 SHALL have parameter PIX_W, default 12, frame-buffer pixel width (1..16).
REQ-002 SHALL have parameter ADDR_W, default 19, frame-buffer address width.
REQ-003 SHALL have parameter FRAME_SEC, default 1200, 512-byte sectors per frame; frame words = FRAME_SEC*256.
REQ-004 SHALL have parameter SLOT_N, default 16, photo slots; slot index width SW = clog2(SLOT_N).
REQ-005 SHALL have parameter BASE_SEC, default 32'd8192, sector address of slot 0.
REQ-006 SHALL have parameter TO_CYC, default 1_000_000, busy-wait timeout in cycles.
REQ-007 SHALL have port sys_clk  in  1  the single clock; reset is synchronous and active-high.
REQ-008 SHALL have port sys_rst  in  1  synchronous active-high reset, sampled on sys_clk.
REQ-009 SHALL have port cmd_valid  in  1  command strobe, accepted only when mode==LIVE.
REQ-010 SHALL have port cmd_op  in  2  1=save, 2=load, 0/3 ignored.
REQ-011 SHALL have port cmd_slot  in  SW  target slot.
REQ-012 SHALL have port mode  out  2  0 LIVE, 1 SAVE, 2 LOAD, 3 ERR.
REQ-013 SHALL have port cam_wr_gate  out  1  camera may write port A; high only in LIVE.
REQ-014 SHALL have port vga_addr  in  ADDR_W  VGA read address.
REQ-015 SHALL have port buf_addr  out  ADDR_W  frame-buffer port B address.
REQ-016 SHALL have port buf_we  out  1  port B write enable.
REQ-017 SHALL have port buf_wdata  out  PIX_W  port B write data.
REQ-018 SHALL have port buf_rdata  in  PIX_W  port B read data, 1-cycle latency.
REQ-019 SHALL have port sd_init_done  in  1  SD controller ready.
REQ-020 SHALL have port wr_start_en  out  1  one-cycle sector-write start pulse.
REQ-021 SHALL have port wr_busy  in  1  sector write in progress.
REQ-022 SHALL have port wr_req  in  1  SD controller requests next 16-bit word.
REQ-023 SHALL have port wr_data  out  16  zero-extended buf_rdata.
REQ-024 SHALL have port rd_start_en  out  1  one-cycle sector-read start pulse.
REQ-025 SHALL have port rd_busy  in  1  sector read in progress.
REQ-026 SHALL have port rd_val_en  in  1  rd_val_data valid.
REQ-027 SHALL have port rd_val_data  in  16  read word; low PIX_W bits used.
REQ-028 SHALL have port sec_addr  out  32  sector address for both read and write.
REQ-029 SHALL have port done  out  1  one-cycle pulse on successful save/load completion.
REQ-030 SHALL have port err  out  1  level, high in ERR.

Function
REQ-031 States LIVE, SAVE_ST, SAVE_XF, LOAD_ST, LOAD_XF, ERR; mode = 1 for SAVE_*, 2 for LOAD_*.
REQ-032 In LIVE: buf_addr = vga_addr combinationally, buf_we=0; cmd_valid with op 1/2 and sd_init_done=1 latches slot, clears word/sector counters, enters SAVE_ST/LOAD_ST next cycle; other commands ignored; commands outside LIVE ignored.
REQ-033 sec_addr = BASE_SEC + slot*FRAME_SEC + sec_cnt, registered, stable for the whole sector.
REQ-034 SAVE_ST: wait wr_busy=0, pulse wr_start_en one cycle, enter SAVE_XF; buf_addr = word counter, pre-addressed so buf_rdata is valid by first wr_req.
REQ-035 SAVE_XF: each wr_req advances word counter by 1; word 256 of a sector completes when wr_busy falls.
REQ-036 LOAD_ST/LOAD_XF mirror save: rd_start_en pulse; each rd_val_en writes rd_val_data[PIX_W-1:0] with buf_we=1 at buf_addr = word counter, then increments.
REQ-037 On sector completion: sec_cnt+1; sec_cnt==FRAME_SEC-1 -> done pulse, return to LIVE; else back to *_ST.
REQ-038 Word counter never exceeds FRAME_SEC*256-1; extra wr_req/rd_val_en beyond 256 per sector are ignored.
REQ-039 Timeout counter restarts on every state entry and on each wr_req/rd_val_en; reaching TO_CYC -> ERR.
REQ-040 ERR: err=1, buf_we=0, cam_wr_gate=0; leaves only via cmd_valid with op 0 (clear) -> LIVE.
REQ-041 sd_init_done falling during a transfer -> ERR next cycle.
REQ-042 wr_start_en and rd_start_en are never high in the same cycle.

Reset
REQ-043 sys_rst high: state LIVE, counters 0, all pulses 0, err=0, cam_wr_gate=1, sec_addr=BASE_SEC; mid-transfer reset aborts with no further start pulses.

Verification
REQ-044 Save slot 2 with FRAME_SEC=2: 2 wr_start_en pulses, sec_addr 8192+4 then 8197, 512 wr_req, wr_data = buf contents 0..511, done once, mode back to 0.
REQ-045 Load slot 0: rd_val_en stream 0x0ABC.. writes buf_addr 0..511 with low 12 bits; cam_wr_gate=0 throughout.
REQ-046 cmd_valid during SAVE_XF: ignored, sector sequence unchanged.
REQ-047 wr_busy stuck high with TO_CYC=100: ERR after 100 cycles; op 0 command returns to LIVE.
REQ-048 sys_rst asserted mid-LOAD_XF: next cycle mode=0, buf_we=0, err=0.
